// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
//   Shared definitions for the pipelined_mips32 core: opcode constants, the
//   decoded instruction class, instruction field helpers and the pipeline
//   register layouts.
// -----------------------------------------------------------------------------
package mips32_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned RAW   = 5;
   localparam int unsigned NREGS = 32;

   localparam logic [5:0] OP_ADD   = 6'h00;
   localparam logic [5:0] OP_SUB   = 6'h01;
   localparam logic [5:0] OP_AND   = 6'h02;
   localparam logic [5:0] OP_OR    = 6'h03;
   localparam logic [5:0] OP_SLT   = 6'h04;
   localparam logic [5:0] OP_MUL   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h08;
   localparam logic [5:0] OP_SW    = 6'h09;
   localparam logic [5:0] OP_ADDI  = 6'h0A;
   localparam logic [5:0] OP_SUBI  = 6'h0B;
   localparam logic [5:0] OP_SLTI  = 6'h0C;
   localparam logic [5:0] OP_BNEQZ = 6'h0D;
   localparam logic [5:0] OP_BEQZ  = 6'h0E;
   localparam logic [5:0] OP_HLT   = 6'h3F;

   // NOP must stay encoded as zero: an all-zero pipeline register is a bubble
   typedef enum logic [2:0] {
      NOP    = 3'd0,
      RR_ALU = 3'd1,
      RM_ALU = 3'd2,
      LOAD   = 3'd3,
      STORE  = 3'd4,
      BRANCH = 3'd5,
      HALT   = 3'd6
   } instr_t;

   typedef struct packed {
      instr_t            ty;
      logic [5:0]        op;
      logic [RAW-1:0]    rs;
      logic [RAW-1:0]    rt;
      logic [RAW-1:0]    dest;   // zero when the instruction writes no register
      logic [XLEN-1:0]   a;
      logic [XLEN-1:0]   b;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   npc;
   } id_ex_t;

   typedef struct packed {
      instr_t            ty;
      logic [RAW-1:0]    dest;
      logic [XLEN-1:0]   alu;
      logic [XLEN-1:0]   sd;     // store data
   } ex_mem_t;

   typedef struct packed {
      instr_t            ty;
      logic [RAW-1:0]    dest;
      logic [XLEN-1:0]   alu;
      logic [XLEN-1:0]   lmd;    // load data
   } mem_wb_t;

   function automatic logic [5:0] f_op(input logic [31:0] ir);
      return ir[31:26];
   endfunction

   function automatic logic [RAW-1:0] f_rs(input logic [31:0] ir);
      return ir[25:21];
   endfunction

   function automatic logic [RAW-1:0] f_rt(input logic [31:0] ir);
      return ir[20:16];
   endfunction

   function automatic logic [RAW-1:0] f_rd(input logic [31:0] ir);
      return ir[15:11];
   endfunction

   function automatic logic [XLEN-1:0] f_imm(input logic [31:0] ir);
      return {{16{ir[15]}}, ir[15:0]};
   endfunction

   function automatic instr_t decode(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
         OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
         OP_LW:                                         return LOAD;
         OP_SW:                                         return STORE;
         OP_BNEQZ, OP_BEQZ:                             return BRANCH;
         OP_HLT:                                        return HALT;
         default:                                       return NOP;
      endcase
   endfunction

endpackage

// File: rtl/pipelined_mips32_if.sv
// -----------------------------------------------------------------------------
// pipelined_mips32_if
//   Status bundle of the core.
//     halted : high once HLT has retired; sticky until reset
//   master = core side (drives), slave = observer side.
// -----------------------------------------------------------------------------
interface pipelined_mips32_if;
   logic halted;

   modport master (output halted);
   modport slave  (input  halted);
endinterface

// File: rtl/mips32_regfile.sv
// -----------------------------------------------------------------------------
// mips32_regfile
//   32 x 32 register file, two asynchronous read ports, one write port.
//   Write-first: a write in progress is visible on the read ports in the same
//   cycle. R0 always reads zero and ignores writes.
//   Ports:
//     clk_i                 clock
//     we_i/waddr_i/wdata_i  write port
//     raddr_a_i/rdata_a_o   read port A
//     raddr_b_i/rdata_b_o   read port B
// -----------------------------------------------------------------------------
module mips32_regfile
   import mips32_pkg::*;
(
   input  logic            clk_i,
   input  logic            we_i,
   input  logic [RAW-1:0]  waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [RAW-1:0]  raddr_a_i,
   output logic [XLEN-1:0] rdata_a_o,
   input  logic [RAW-1:0]  raddr_b_i,
   output logic [XLEN-1:0] rdata_b_o
);

   logic [XLEN-1:0] regbank [NREGS];

   always_ff @(posedge clk_i) begin
      if (we_i && (waddr_i != '0)) begin
         regbank[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_a_o = regbank[raddr_a_i];
      if (we_i && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
      if (raddr_a_i == '0)                rdata_a_o = '0;
   end

   always_comb begin
      rdata_b_o = regbank[raddr_b_i];
      if (we_i && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
      if (raddr_b_i == '0)                rdata_b_o = '0;
   end

endmodule

// File: rtl/pipelined_mips32.sv
// -----------------------------------------------------------------------------
// pipelined_mips32
//   5-stage in-order MIPS-subset core (IF/ID/EX/MEM/WB) with internal
//   instruction memory, data memory and register file. Memories are loaded
//   externally; the core runs from PC 0 after reset until HLT retires.
//   Ports:
//     clk  clock, all state on rising edge
//     rst  synchronous active-high reset (memories and registers untouched)
//     bus  status interface (master): halted
// -----------------------------------------------------------------------------
module pipelined_mips32
   import mips32_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 1024,
   parameter int unsigned DMEM_DEPTH = 1024
) (
   input  logic               clk,
   input  logic               rst,
   pipelined_mips32_if.master bus
);

   localparam int unsigned IAW = $clog2(IMEM_DEPTH);
   localparam int unsigned DAW = $clog2(DMEM_DEPTH);

   logic [31:0] instr_mem [IMEM_DEPTH];
   logic [31:0] data_mem  [DMEM_DEPTH];

   logic [31:0] pc_q, pc_d;
   logic        stopped_q, stopped_d;
   logic        halted_q, halted_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] if_id_ir_q, if_id_ir_d;
   logic [31:0] if_id_npc_q, if_id_npc_d;
   id_ex_t      id_ex_q, id_ex_d;
   ex_mem_t     ex_mem_q, ex_mem_d;
   mem_wb_t     mem_wb_q, mem_wb_d;

   // ---------------- IF ----------------
   logic [IAW-1:0] imem_idx;
   logic [31:0]    if_ir;

   assign imem_idx = IAW'(pc_q % IMEM_DEPTH);
   assign if_ir    = instr_mem[imem_idx];

   // ---------------- ID ----------------
   instr_t          id_ty;
   logic [RAW-1:0]  id_rs, id_rt, id_dest;
   logic [XLEN-1:0] id_a, id_b;

   assign id_ty = if_id_valid_q ? decode(f_op(if_id_ir_q)) : NOP;
   assign id_rs = f_rs(if_id_ir_q);
   assign id_rt = f_rt(if_id_ir_q);

   always_comb begin
      case (id_ty)
         RR_ALU:       id_dest = f_rd(if_id_ir_q);
         RM_ALU, LOAD: id_dest = f_rt(if_id_ir_q);
         default:      id_dest = '0;
      endcase
   end

   // ---------------- WB ----------------
   logic            wb_we;
   logic [XLEN-1:0] wb_data;

   assign wb_data = (mem_wb_q.ty == LOAD) ? mem_wb_q.lmd : mem_wb_q.alu;
   assign wb_we   = !rst && !halted_q && (mem_wb_q.dest != '0);

   mips32_regfile u_regfile (
      .clk_i     (clk),
      .we_i      (wb_we),
      .waddr_i   (mem_wb_q.dest),
      .wdata_i   (wb_data),
      .raddr_a_i (id_rs),
      .rdata_a_o (id_a),
      .raddr_b_i (id_rt),
      .rdata_b_o (id_b)
   );

   // ---------------- EX ----------------
   logic            ex_mem_fwd, ex_taken;
   logic [XLEN-1:0] ex_a, ex_b, ex_alu, ex_target;

   // EX/MEM only carries a usable value for ALU ops; a load there is a
   // load-use violation that software avoids.
   assign ex_mem_fwd = ((ex_mem_q.ty == RR_ALU) || (ex_mem_q.ty == RM_ALU))
                       && (ex_mem_q.dest != '0);

   // Older source applied first so the younger EX/MEM result wins.
   always_comb begin
      ex_a = id_ex_q.a;
      ex_b = id_ex_q.b;
      if ((mem_wb_q.dest != '0) && (mem_wb_q.dest == id_ex_q.rs)) ex_a = wb_data;
      if ((mem_wb_q.dest != '0) && (mem_wb_q.dest == id_ex_q.rt)) ex_b = wb_data;
      if (ex_mem_fwd && (ex_mem_q.dest == id_ex_q.rs)) ex_a = ex_mem_q.alu;
      if (ex_mem_fwd && (ex_mem_q.dest == id_ex_q.rt)) ex_b = ex_mem_q.alu;
   end

   always_comb begin
      ex_alu = '0;
      case (id_ex_q.op)
         OP_ADD:                ex_alu = ex_a + ex_b;
         OP_SUB:                ex_alu = ex_a - ex_b;
         OP_AND:                ex_alu = ex_a & ex_b;
         OP_OR:                 ex_alu = ex_a | ex_b;
         OP_SLT:                ex_alu = {31'b0, ($signed(ex_a) < $signed(ex_b))};
         OP_MUL:                ex_alu = ex_a * ex_b;
         OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + id_ex_q.imm;
         OP_SUBI:               ex_alu = ex_a - id_ex_q.imm;
         OP_SLTI:               ex_alu = {31'b0, ($signed(ex_a) < $signed(id_ex_q.imm))};
         default:               ex_alu = '0;
      endcase
   end

   assign ex_taken  = (id_ex_q.ty == BRANCH) &&
                      ((id_ex_q.op == OP_BEQZ) ? (ex_a == '0) : (ex_a != '0));
   assign ex_target = id_ex_q.npc + id_ex_q.imm;

   // ---------------- MEM ----------------
   logic [DAW-1:0] dmem_idx;

   assign dmem_idx = DAW'(ex_mem_q.alu % DMEM_DEPTH);

   // ---------------- next state ----------------
   logic fetch_stall;

   always_comb begin
      // A HLT in ID stops fetch for good unless the branch ahead of it is
      // taken, in which case the HLT is flushed and fetch follows the target.
      fetch_stall = stopped_q || halted_q || ((id_ty == HALT) && !ex_taken);
      stopped_d   = stopped_q || ((id_ty == HALT) && !ex_taken);
      halted_d    = halted_q || (mem_wb_q.ty == HALT);

      pc_d          = pc_q + 32'd1;
      if_id_valid_d = 1'b1;
      if_id_ir_d    = if_ir;
      if_id_npc_d   = pc_q + 32'd1;
      if (ex_taken) begin
         pc_d          = ex_target;
         if_id_valid_d = 1'b0;
      end else if (fetch_stall) begin
         pc_d          = pc_q;
         if_id_valid_d = 1'b0;
      end

      id_ex_d      = '0;
      id_ex_d.ty   = id_ty;
      id_ex_d.op   = f_op(if_id_ir_q);
      id_ex_d.rs   = id_rs;
      id_ex_d.rt   = id_rt;
      id_ex_d.dest = id_dest;
      id_ex_d.a    = id_a;
      id_ex_d.b    = id_b;
      id_ex_d.imm  = f_imm(if_id_ir_q);
      id_ex_d.npc  = if_id_npc_q;
      if (ex_taken) id_ex_d = '0;

      ex_mem_d      = '0;
      ex_mem_d.ty   = id_ex_q.ty;
      ex_mem_d.dest = id_ex_q.dest;
      ex_mem_d.alu  = ex_alu;
      ex_mem_d.sd   = ex_b;

      mem_wb_d      = '0;
      mem_wb_d.ty   = ex_mem_q.ty;
      mem_wb_d.dest = ex_mem_q.dest;
      mem_wb_d.alu  = ex_mem_q.alu;
      mem_wb_d.lmd  = data_mem[dmem_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= '0;
         stopped_q     <= 1'b0;
         halted_q      <= 1'b0;
         if_id_valid_q <= 1'b0;
         if_id_ir_q    <= '0;
         if_id_npc_q   <= '0;
         id_ex_q       <= '0;
         ex_mem_q      <= '0;
         mem_wb_q      <= '0;
      end else begin
         pc_q          <= pc_d;
         stopped_q     <= stopped_d;
         halted_q      <= halted_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_ir_q    <= if_id_ir_d;
         if_id_npc_q   <= if_id_npc_d;
         id_ex_q       <= id_ex_d;
         ex_mem_q      <= ex_mem_d;
         mem_wb_q      <= mem_wb_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !halted_q && (ex_mem_q.ty == STORE)) begin
         data_mem[dmem_idx] <= ex_mem_q.sd;
      end
   end

   assign bus.halted = halted_q;

endmodule

// File: tb/tb_pipelined_mips32.sv
// -----------------------------------------------------------------------------
// tb_pipelined_mips32
//   Directed programs for pipelined_mips32. Expected register / memory
//   contents are queued when a program is loaded and compared after HLT.
// -----------------------------------------------------------------------------
module tb_pipelined_mips32;
   import mips32_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pipelined_mips32_if bus ();

   pipelined_mips32 #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      bit          is_mem;
      int unsigned idx;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] prog[$];
   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   int unsigned n_fail  = 0;

   localparam logic [31:0] I_HLT = {OP_HLT, 26'b0};
   localparam logic [31:0] I_NOP = 32'hF000_0000;

   function automatic logic [31:0] rr(input logic [5:0] op, input int unsigned rd,
                                      input int unsigned rs, input int unsigned rt);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
   endfunction

   function automatic logic [31:0] ri(input logic [5:0] op, input int unsigned rt,
                                      input int unsigned rs, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic exp_reg(input string tag, input int unsigned idx, input logic [31:0] v);
      sb.push_back('{tag, 1'b0, idx, v});
   endtask

   task automatic exp_mem(input string tag, input int unsigned idx, input logic [31:0] v);
      sb.push_back('{tag, 1'b1, idx, v});
   endtask

   task automatic init_state();
      for (int i = 0; i < 1024; i++) begin
         dut.instr_mem[i] = '0;
         dut.data_mem[i]  = '0;
      end
      for (int i = 0; i < 32; i++) dut.u_regfile.regbank[i] = 32'(i);
      foreach (prog[i]) dut.instr_mem[i] = prog[i];
   endtask

   task automatic start();
      @(negedge clk);
      rst = 1'b1;
      init_state();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_to_halt(input string tag);
      int unsigned c;
      c = 0;
      while ((bus.halted !== 1'b1) && (c < 400)) begin
         @(negedge clk);
         c++;
      end
      check({tag, ".halted"}, 32'(bus.halted), 32'd1);
   endtask

   task automatic drain();
      exp_t e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = e.is_mem ? dut.data_mem[e.idx] : dut.u_regfile.regbank[e.idx];
         check(e.tag, obs, e.exp);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: arithmetic with spacers
      prog = '{ri(OP_ADDI, 1, 0, 16'd10), ri(OP_ADDI, 2, 0, 16'd20), ri(OP_ADDI, 3, 0, 16'd25),
               rr(OP_OR, 15, 7, 7), rr(OP_OR, 15, 7, 7), rr(OP_ADD, 4, 1, 2),
               rr(OP_OR, 15, 7, 7), rr(OP_ADD, 5, 4, 3), I_HLT};
      start();
      check("reset.halted", 32'(bus.halted), 32'd0);
      check("reset.pc", dut.pc_q, 32'd0);
      exp_reg("t1.R1", 1, 32'd10);
      exp_reg("t1.R2", 2, 32'd20);
      exp_reg("t1.R3", 3, 32'd25);
      exp_reg("t1.R4", 4, 32'd30);
      exp_reg("t1.R5", 5, 32'd55);
      exp_reg("t1.R15", 15, 32'd7);
      run_to_halt("t1");
      drain();
      check("t1.pc", dut.pc_q, 32'd9);

      // 2: same arithmetic, back-to-back dependencies
      prog = '{ri(OP_ADDI, 1, 0, 16'd10), ri(OP_ADDI, 2, 0, 16'd20), ri(OP_ADDI, 3, 0, 16'd25),
               rr(OP_ADD, 4, 1, 2), rr(OP_ADD, 5, 4, 3), I_HLT};
      start();
      exp_reg("t2.R1", 1, 32'd10);
      exp_reg("t2.R2", 2, 32'd20);
      exp_reg("t2.R3", 3, 32'd25);
      exp_reg("t2.R4", 4, 32'd30);
      exp_reg("t2.R5", 5, 32'd55);
      run_to_halt("t2");
      drain();

      // 3: store / load
      prog = '{ri(OP_ADDI, 1, 0, 16'd120), ri(OP_ADDI, 2, 0, 16'd85), ri(OP_SW, 2, 1, 16'd0),
               I_NOP, ri(OP_LW, 3, 1, 16'd0), I_NOP, rr(OP_ADD, 4, 3, 3), I_HLT};
      start();
      exp_mem("t3.mem120", 120, 32'd85);
      exp_reg("t3.R3", 3, 32'd85);
      exp_reg("t3.R4", 4, 32'd170);
      run_to_halt("t3");
      drain();

      // ALU variety, signed compares and wrap-around
      prog = '{ri(OP_ADDI, 1, 0, 16'hFFFD), ri(OP_ADDI, 2, 0, 16'd7), rr(OP_SUB, 11, 1, 2),
               rr(OP_SLT, 12, 1, 2), rr(OP_MUL, 13, 1, 2), rr(OP_AND, 14, 2, 1),
               ri(OP_SLTI, 16, 2, 16'hFFFF), ri(OP_SUBI, 17, 2, 16'd10), rr(OP_SLT, 18, 2, 1),
               I_HLT};
      start();
      exp_reg("alu.SUB", 11, 32'hFFFF_FFF6);
      exp_reg("alu.SLT", 12, 32'd1);
      exp_reg("alu.MUL", 13, 32'hFFFF_FFEB);
      exp_reg("alu.AND", 14, 32'd5);
      exp_reg("alu.SLTI", 16, 32'd0);
      exp_reg("alu.SUBI", 17, 32'hFFFF_FFFD);
      exp_reg("alu.SLTrev", 18, 32'd0);
      run_to_halt("alu");
      drain();

      // 4a: BEQZ taken
      prog = '{ri(OP_ADDI, 1, 0, 16'd0), ri(OP_BEQZ, 0, 1, 16'd2), ri(OP_ADDI, 5, 0, 16'd7),
               ri(OP_ADDI, 6, 0, 16'd8), ri(OP_ADDI, 7, 0, 16'd9), I_HLT};
      start();
      exp_reg("t4a.R5", 5, 32'd5);
      exp_reg("t4a.R6", 6, 32'd6);
      exp_reg("t4a.R7", 7, 32'd9);
      run_to_halt("t4a");
      drain();

      // 4b: BNEQZ not taken
      prog = '{ri(OP_ADDI, 1, 0, 16'd0), ri(OP_BNEQZ, 0, 1, 16'd2), ri(OP_ADDI, 5, 0, 16'd7),
               ri(OP_ADDI, 6, 0, 16'd8), ri(OP_ADDI, 7, 0, 16'd9), I_HLT};
      start();
      exp_reg("t4b.R5", 5, 32'd7);
      exp_reg("t4b.R6", 6, 32'd8);
      exp_reg("t4b.R7", 7, 32'd9);
      run_to_halt("t4b");
      drain();

      // taken branch flushes a HLT in ID; R0 writes discarded and not forwarded
      prog = '{ri(OP_BEQZ, 0, 0, 16'd1), I_HLT, ri(OP_ADDI, 9, 0, 16'd3),
               ri(OP_ADDI, 0, 0, 16'd5), rr(OP_ADD, 10, 0, 0), I_HLT};
      start();
      exp_reg("flush.R9", 9, 32'd3);
      exp_reg("flush.R10", 10, 32'd0);
      exp_reg("flush.R0", 0, 32'd0);
      run_to_halt("flush");
      drain();
      check("flush.pc", dut.pc_q, 32'd6);

      // 5: nothing after HLT executes
      prog = '{I_HLT, ri(OP_ADDI, 8, 0, 16'd1), ri(OP_SW, 8, 0, 16'd5)};
      start();
      dut.data_mem[5] = 32'd55;
      exp_reg("t5.R8", 8, 32'd8);
      exp_mem("t5.mem5", 5, 32'd55);
      run_to_halt("t5");
      repeat (10) @(negedge clk);
      drain();
      check("t5.halted_sticky", 32'(bus.halted), 32'd1);
      check("t5.pc_frozen", dut.pc_q, 32'd1);

      // 6: reset clears halted; reset mid-run aborts in-flight writes
      prog = '{ri(OP_ADDI, 20, 0, 16'd1), ri(OP_SW, 22, 0, 16'd7), ri(OP_ADDI, 21, 0, 16'd2), I_HLT};
      init_state();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6.rst_halted", 32'(bus.halted), 32'd0);
      check("t6.rst_pc", dut.pc_q, 32'd0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      prog = '{ri(OP_ADDI, 24, 0, 16'd9), I_HLT, I_NOP, I_NOP};
      foreach (prog[i]) dut.instr_mem[i] = prog[i];
      @(negedge clk);
      rst = 1'b0;
      check("t6.mid_pc", dut.pc_q, 32'd0);
      check("t6.mid_halted", 32'(bus.halted), 32'd0);
      exp_reg("t6.R20", 20, 32'd20);
      exp_reg("t6.R21", 21, 32'd21);
      exp_mem("t6.mem7", 7, 32'd0);
      exp_reg("t6.R24", 24, 32'd9);
      run_to_halt("t6");
      drain();
      check("t6.pc", dut.pc_q, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
